// File: rtl/pool_stream_buffer.sv
// Output buffer for the max-pooling stage: FWFT FIFO with per-frame last tagging and loss/length flags.
// Optional build macro POOL_BUF_RELU_EN clamps negative words to zero as they are written.
module pool_stream_buffer #(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 16,
   parameter int FRAME_LEN = 16
) (
   input  logic                       clk,
   input  logic                       master_rst,
   input  logic                       ce,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       valid_in,
   input  logic                       end_in,
   input  logic                       m_ready,
   output logic [WIDTH-1:0]           m_data,
   output logic                       m_valid,
   output logic                       m_last,
   output logic                       frame_done,
   output logic                       overflow,
   output logic                       len_err,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

   // each entry is {last_tag, word}
   logic [WIDTH:0]  r_mem [DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [LW-1:0]   r_level;
   logic [CW-1:0]   r_in_cnt;
   logic            r_frame_done;
   logic            r_overflow;
   logic            r_len_err;

   logic            w_wr;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_accept;
   logic            w_cnt_last;
   logic            w_tag;
   logic            w_len_bad;
   logic [WIDTH-1:0] w_word;
   logic [WIDTH:0]  w_head;

   always_comb begin
      w_wr       = ce & valid_in;
      w_empty    = (r_level == '0);
      w_full     = (r_level == LVL_FULL);
      w_pop      = ~w_empty & m_ready;
      // a full FIFO still takes a word when the head leaves in the same cycle
      w_accept   = w_wr & (~w_full | w_pop);
      w_cnt_last = (r_in_cnt == CNT_LAST);
      w_tag      = w_cnt_last | end_in;
      w_len_bad  = end_in ^ w_cnt_last;
      w_head     = r_mem[r_rd_ptr];
   end

`ifdef POOL_BUF_RELU_EN
   always_comb begin
      w_word = data_in[WIDTH-1] ? '0 : data_in;
   end
`else
   always_comb begin
      w_word = data_in;
   end
`endif

   // storage is never reset; validity comes from r_level
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wr_ptr] <= {w_tag, w_word};
      end
   end

   always_ff @(posedge clk) begin
      if (master_rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_in_cnt     <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_len_err    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_accept, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
         // the frame counter follows the pooler even when the word is dropped
         if (w_wr) begin
            r_in_cnt <= w_tag ? '0 : r_in_cnt + CW'(1);
            if (w_len_bad) begin
               r_len_err <= 1'b1;
            end
            if (~w_accept) begin
               r_overflow <= 1'b1;
            end
         end
         r_frame_done <= w_pop & w_head[WIDTH];
      end
   end

   always_comb begin
      m_valid    = ~w_empty;
      m_data     = m_valid ? w_head[WIDTH-1:0] : '0;
      m_last     = m_valid & w_head[WIDTH];
      frame_done = r_frame_done;
      overflow   = r_overflow;
      len_err    = r_len_err;
      level      = r_level;
   end

endmodule

// File: tb/tb_pool_stream_buffer.sv
// Randomized bench for pool_stream_buffer against a queue-based reference model.
// Honors POOL_BUF_RELU_EN the same way the design does.
module tb_pool_stream_buffer;

   localparam int WIDTH     = 32;
   localparam int DEPTH     = 16;
   localparam int FRAME_LEN = 16;
   localparam int LW        = $clog2(DEPTH + 1);
   localparam int N_CYC     = 4000;

   typedef struct packed {
      logic             last;
      logic [WIDTH-1:0] word;
   } ent_t;

   logic             clk;
   logic             master_rst;
   logic             ce;
   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             end_in;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             frame_done;
   logic             overflow;
   logic             len_err;
   logic [LW-1:0]    level;

   int n_total = 0;
   int n_bad   = 0;

   ent_t q[$];
   int   mdl_cnt;
   logic mdl_ovf;
   logic mdl_lerr;
   logic mdl_fd;
   int   max_level;
   int   n_fd;
   int   n_ovf_rise;
   int   n_lerr_rise;

   pool_stream_buffer #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .clk        (clk),
      .master_rst (master_rst),
      .ce         (ce),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .end_in     (end_in),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_last     (m_last),
      .frame_done (frame_done),
      .overflow   (overflow),
      .len_err    (len_err),
      .level      (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] stored_word(input logic [WIDTH-1:0] d);
`ifdef POOL_BUF_RELU_EN
      return d[WIDTH-1] ? '0 : d;
`else
      return d;
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      mdl_cnt  = 0;
      mdl_ovf  = 1'b0;
      mdl_lerr = 1'b0;
      mdl_fd   = 1'b0;
   endtask

   // advance the model by one clock using the inputs currently driven
   task automatic model_step();
      bit   pop;
      bit   wr;
      bit   tag;
      bit   room;
      ent_t e;
      if (master_rst) begin
         model_reset();
         return;
      end
      pop  = (q.size() > 0) && m_ready;
      wr   = ce && valid_in;
      room = (q.size() < DEPTH) || pop;
      mdl_fd = pop && q[0].last;
      if (wr) begin
         tag = (mdl_cnt == FRAME_LEN - 1) || end_in;
         if (end_in != (mdl_cnt == FRAME_LEN - 1)) mdl_lerr = 1'b1;
         mdl_cnt = tag ? 0 : mdl_cnt + 1;
      end
      if (pop) void'(q.pop_front());
      if (wr) begin
         if (room) begin
            e.last = tag;
            e.word = stored_word(data_in);
            q.push_back(e);
         end else begin
            mdl_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare_outputs();
      logic [WIDTH-1:0] exp_data;
      logic             exp_last;
      exp_data = (q.size() > 0) ? q[0].word : '0;
      exp_last = (q.size() > 0) ? q[0].last : 1'b0;
      check_val("m_valid",    64'(m_valid),    64'(q.size() > 0));
      check_val("m_data",     64'(m_data),     64'(exp_data));
      check_val("m_last",     64'(m_last),     64'(exp_last));
      check_val("level",      64'(level),      64'(q.size()));
      check_val("frame_done", 64'(frame_done), 64'(mdl_fd));
      check_val("overflow",   64'(overflow),   64'(mdl_ovf));
      check_val("len_err",    64'(len_err),    64'(mdl_lerr));
   endtask

   initial begin
      int   phase;
      logic prev_ovf;
      logic prev_lerr;
      master_rst = 1'b1;
      ce         = 1'b0;
      data_in    = '0;
      valid_in   = 1'b0;
      end_in     = 1'b0;
      m_ready    = 1'b0;
      model_reset();
      max_level   = 0;
      n_fd        = 0;
      n_ovf_rise  = 0;
      n_lerr_rise = 0;
      prev_ovf    = 1'b0;
      prev_lerr   = 1'b0;
      repeat (2) @(posedge clk);

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         compare_outputs();
         if (int'(level) > max_level) max_level = int'(level);
         if (frame_done) n_fd++;
         if (overflow && !prev_ovf) n_ovf_rise++;
         if (len_err && !prev_lerr) n_lerr_rise++;
         prev_ovf  = overflow;
         prev_lerr = len_err;

         phase = (cyc / 500) % 4;
         master_rst = (cyc % 500 == 0) || ($urandom_range(0, 299) == 0);
         ce       = ($urandom_range(0, 9) != 0);
         valid_in = ($urandom_range(0, 9) < 7);
         data_in  = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 1000));
         m_ready  = 1'b1;
         end_in   = (mdl_cnt == FRAME_LEN - 1);
         case (phase)
            0: begin
               if (cyc < 20) begin
                  ce = 1'b1;
                  valid_in = (cyc >= 2) && (cyc < 4);
                  data_in  = (cyc == 2) ? 32'hFFFF_FFF0 : 32'h0000_0005;
               end
            end
            1: begin
               m_ready  = ($urandom_range(0, 9) == 0);
               valid_in = ($urandom_range(0, 9) != 0);
            end
            2: begin
               m_ready = $urandom_range(0, 1) == 1;
               if ($urandom_range(0, 9) == 0) end_in = ~end_in;
            end
            default: begin
               ce       = 1'b1;
               valid_in = 1'b1;
               m_ready  = ((cyc % 40) >= 24);
            end
         endcase
         model_step();
      end

      @(negedge clk);
      compare_outputs();
      check_val("saw_full_level",  64'(max_level == DEPTH), 64'(1));
      check_val("saw_frame_done",  64'(n_fd > 0),           64'(1));
      check_val("saw_overflow",    64'(n_ovf_rise > 0),     64'(1));
      check_val("saw_len_err",     64'(n_lerr_rise > 0),    64'(1));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
